// File: rtl/adc_lane_delay.sv
// adc_lane_delay: per-lane 1..2^TAP_WIDTH cycle programmable delay with tap command port and ready timer
module adc_lane_delay #(
  parameter int DATA_WIDTH = 14,
  parameter int TAP_WIDTH = 5,
  parameter int INIT_TAP = 0,
  parameter int RDY_CYCLES = 16,
  localparam int LW = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk_del,
  input  logic                  rst_idelay,
  input  logic [DATA_WIDTH-1:0] adc_dat_in,
  input  logic                  adc_or_in,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [LW-1:0]         cmd_lane,
  input  logic [TAP_WIDTH-1:0]  cmd_value,
  output logic                  cmd_err,
  input  logic [LW-1:0]         rd_lane,
  output logic [TAP_WIDTH-1:0]  rd_value,
  output logic                  rdy,
  output logic [DATA_WIDTH-1:0] adc_dat_out,
  output logic                  adc_or_out
);
  localparam int NL = DATA_WIDTH + 1;
  localparam int DEPTH = 2 ** TAP_WIDTH;
  localparam logic [LW-1:0] LAST_LANE = LW'(DATA_WIDTH);
  localparam logic [TAP_WIDTH-1:0] TAP_MAX = '1;
  localparam logic [TAP_WIDTH-1:0] TAP_ONE = TAP_WIDTH'(1);
  localparam logic [TAP_WIDTH-1:0] TAP_INIT = TAP_WIDTH'(INIT_TAP);
  typedef enum logic {WAIT, READY} state_t;
  state_t state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [TAP_WIDTH-1:0] tap [NL];
  logic [TAP_WIDTH-1:0] tap_nxt [NL];
  logic [DEPTH-1:0] sh [NL];
  logic [NL-1:0] lane_in, lane_out;
  logic acc;
  assign rdy = state == READY;
  assign cmd_ready = rdy;
  assign acc = cmd_valid && rdy;
  assign lane_in = {adc_or_in, adc_dat_in};
  assign {adc_or_out, adc_dat_out} = lane_out;
  always_ff @(posedge clk_del) begin
    state <= rst_idelay ? WAIT : state_nxt;
    cnt <= rst_idelay ? '0 : cnt_nxt;
  end
  always_comb begin
    state_nxt = (state == WAIT && cnt == 16'(RDY_CYCLES - 1)) ? READY : state;
    cnt_nxt = state == WAIT ? cnt + 16'd1 : cnt;
  end
  always_comb begin
    for (int l = 0; l < NL; l++) begin
      tap_nxt[l] = !acc ? tap[l] :
                   cmd_op == 2'd3 ? '0 :
                   cmd_lane != LW'(l) ? tap[l] :
                   cmd_op == 2'd0 ? cmd_value :
                   cmd_op == 2'd1 ? (tap[l] == TAP_MAX ? tap[l] : tap[l] + TAP_ONE) :
                   (tap[l] == '0 ? tap[l] : tap[l] - TAP_ONE);
      lane_out[l] = sh[l][tap[l]];
    end
  end
  always_ff @(posedge clk_del) begin
    cmd_err <= !rst_idelay && acc && cmd_op != 2'd3 && cmd_lane > LAST_LANE;
    rd_value <= (rst_idelay || rd_lane > LAST_LANE) ? '0 : tap_nxt[rd_lane];
    for (int l = 0; l < NL; l++) begin
      tap[l] <= rst_idelay ? TAP_INIT : tap_nxt[l];
      sh[l] <= rst_idelay ? '0 : {sh[l][DEPTH-2:0], lane_in[l]};
    end
  end
endmodule
